// File: rtl/dp_ctrl.sv
// dp_ctrl: fill-then-copy transfer controller for a two-memory datapath.
// Each transfer fills memory A with DEPTH words accepted from the source.
// It then copies A into B, one word per COPY_WR/COPY_INC pair.
// All outputs are decoded combinationally from the state and the inputs.
// Optional feature macro: DP_CTRL_ABORT_EN adds an abort input that
// cancels an in-progress transfer.
module dp_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
`ifdef DP_CTRL_ABORT_EN
  input  logic abort,
`endif
  output logic in_ready,
  output logic dp_clr,
  output logic WEA,
  output logic incA,
  output logic WEB,
  output logic incB,
  output logic busy,
  output logic done
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    COPY_WR,
    COPY_INC,
    DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] fill_cnt_reg, fill_cnt_next;
  logic [CW-1:0] copy_cnt_reg, copy_cnt_next;
  logic          abort_req;

`ifdef DP_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      fill_cnt_reg <= '0;
      copy_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      fill_cnt_reg <= fill_cnt_next;
      copy_cnt_reg <= copy_cnt_next;
    end
  end

  // Next-state, counter update and output decode.
  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    copy_cnt_next = copy_cnt_reg;
    in_ready      = 1'b0;
    dp_clr        = 1'b0;
    WEA           = 1'b0;
    incA          = 1'b0;
    WEB           = 1'b0;
    incB          = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          dp_clr        = 1'b1;
          state_next    = FILL;
          fill_cnt_next = '0;
          copy_cnt_next = '0;
        end
      end

      FILL: begin
        busy = 1'b1;
        if (abort_req) begin
          dp_clr        = 1'b1;
          state_next    = IDLE;
          fill_cnt_next = '0;
          copy_cnt_next = '0;
        end else begin
          in_ready = 1'b1;
          WEA      = in_valid;
          incA     = in_valid;
          if (in_valid) begin
            if (fill_cnt_reg == LAST) begin
              // Address A has wrapped back to 0, ready for the copy reads.
              fill_cnt_next = '0;
              state_next    = COPY_WR;
            end else begin
              fill_cnt_next = fill_cnt_reg + 1'b1;
            end
          end
        end
      end

      COPY_WR: begin
        busy = 1'b1;
        if (abort_req) begin
          dp_clr        = 1'b1;
          state_next    = IDLE;
          fill_cnt_next = '0;
          copy_cnt_next = '0;
        end else begin
          WEB        = 1'b1;
          state_next = COPY_INC;
        end
      end

      COPY_INC: begin
        busy = 1'b1;
        if (abort_req) begin
          dp_clr        = 1'b1;
          state_next    = IDLE;
          fill_cnt_next = '0;
          copy_cnt_next = '0;
        end else begin
          incA = 1'b1;
          incB = 1'b1;
          if (copy_cnt_reg == LAST) begin
            copy_cnt_next = '0;
            state_next    = DONE;
          end else begin
            copy_cnt_next = copy_cnt_reg + 1'b1;
            state_next    = COPY_WR;
          end
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Reset overrides the decode: only the datapath clear stays active.
    if (rst) begin
      in_ready = 1'b0;
      dp_clr   = 1'b1;
      WEA      = 1'b0;
      incA     = 1'b0;
      WEB      = 1'b0;
      incB     = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
    end
  end

endmodule

// File: tb/tb_dp_ctrl.sv
// tb_dp_ctrl: directed and random stimulus for dp_ctrl.
// The reference model tracks a transfer as a count of accepted words and a count of copy steps.
// Expected outputs are derived from those counts every cycle.
module tb_dp_ctrl;

  localparam int DEPTH = 8;

  // Reference model phases.
  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_COPY = 2;
  localparam int M_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic abort = 1'b0;
  logic in_ready, dp_clr, WEA, incA, WEB, incB, busy, done;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  int m_mode = M_IDLE;
  int m_acc = 0;
  int m_cstep = 0;
  int start_cyc = 0;
  bit lat_armed = 1'b0;

  always #5 clk = ~clk;

  dp_ctrl #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
`ifdef DP_CTRL_ABORT_EN
    .abort    (abort),
`endif
    .in_ready (in_ready),
    .dp_clr   (dp_clr),
    .WEA      (WEA),
    .incA     (incA),
    .WEB      (WEB),
    .incB     (incB),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs after the edge, check the settled outputs, advance the model.
  task automatic step(input logic s, input logic v, input logic r, input logic a);
    logic [7:0] e;
    logic [7:0] got;
    bit ab;
    @(posedge clk);
    #1;
    start = s; in_valid = v; rst = r; abort = a;
    cyc++;
    #1;
`ifdef DP_CTRL_ABORT_EN
    ab = a;
`else
    ab = 1'b0;
`endif
    // Bit order: in_ready, dp_clr, WEA, incA, WEB, incB, busy, done.
    e = 8'h00;
    if (r) begin
      e = 8'b0100_0000;
    end else if (m_mode == M_IDLE) begin
      e[6] = s;
    end else if (m_mode == M_DONE) begin
      e[0] = 1'b1;
    end else if (ab) begin
      e = 8'b0100_0010;
    end else if (m_mode == M_FILL) begin
      e = {1'b1, 1'b0, v, v, 1'b0, 1'b0, 1'b1, 1'b0};
    end else begin
      if (m_cstep % 2 == 0) e = 8'b0000_1010;
      else                  e = 8'b0001_0110;
    end
    got = {in_ready, dp_clr, WEA, incA, WEB, incB, busy, done};
    check("outputs", got, e);
    check("wea_web_excl", WEA & WEB, 0);
    check("web_incb_excl", WEB & incB, 0);
    check("in_ready_outside_fill", in_ready & (m_mode != M_FILL), 0);
    if (!r && m_mode == M_DONE && lat_armed) begin
      check("transfer_latency", cyc - start_cyc, 3 * DEPTH + 1);
      lat_armed = 1'b0;
    end
    $display("cyc %0d start=%0b in_valid=%0b rst=%0b abort=%0b -> out=%08b exp=%08b",
             cyc, s, v, r, ab, got, e);

    // Model update for the coming edge.
    if (r) begin
      m_mode = M_IDLE; m_acc = 0; m_cstep = 0; lat_armed = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: if (s) begin
          m_mode = M_FILL; m_acc = 0; m_cstep = 0;
          start_cyc = cyc; lat_armed = 1'b1;
        end
        M_FILL: begin
          if (ab) begin
            m_mode = M_IDLE; lat_armed = 1'b0;
          end else if (v) begin
            m_acc++;
            if (m_acc == DEPTH) begin m_mode = M_COPY; m_cstep = 0; end
          end else begin
            lat_armed = 1'b0;
          end
        end
        M_COPY: begin
          if (ab) begin
            m_mode = M_IDLE; lat_armed = 1'b0;
          end else begin
            m_cstep++;
            if (m_cstep == 2 * DEPTH) m_mode = M_DONE;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  initial begin
    // Reset held for a few cycles.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Continuous transfer: single start pulse, in_valid held high.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 28; i++) step(1'b0, 1'b1, 1'b0, 1'b0);

    // FILL with in_valid toggling.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 44; i++) step(1'b0, logic'(i % 2 == 0), 1'b0, 1'b0);

    // Reset during the third COPY_INC cycle, then a full transfer.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60 && !(m_mode == M_COPY && m_cstep == 5); i++)
      step(1'b0, 1'b1, 1'b0, 1'b0);
    check("reached_copy_inc3", (m_mode == M_COPY && m_cstep == 5), 1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 28; i++) step(1'b0, 1'b1, 1'b0, 1'b0);

    // start held high through back-to-back transfers.
    for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef DP_CTRL_ABORT_EN
    // Abort in the 5th FILL cycle, then a normal transfer.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 28; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
`endif

    // Random traffic with occasional reset and abort.
    for (int i = 0; i < 800; i++) begin
      step(logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 99) == 0),
           logic'($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
